i2c_cmd_sequencer: RTL and testbench
====================================

Name: i2c_cmd_sequencer

Overview:
Command front-end that sits directly upstream of i2c_controller. It buffers host I2C transactions in a command FIFO and launches them one at a time through the controller's new_data/addr/rw/data_in interface. It collects done/ack_error/data_out, retries NACKed transfers and enforces a timeout. It returns one status response per command over a valid/ready channel.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
MAX_RETRY, 2, extra attempts after a NACK (0 = no retry)
TIMEOUT, 4096, cycles allowed from launch to done before abort
GAP, 16, idle cycles between a NACK and the retry launch

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO can accept (= !full)
cmd_addr  in  7  target address
cmd_rw  in  1  1=read, 0=write
cmd_wdata  in  8  write byte
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_addr  out  7  address of completed command
rsp_rdata  out  8  read byte (0 for writes/errors)
rsp_status  out  2  00 ok, 01 nack, 10 timeout
rsp_tries  out  2  attempts used minus 1
pending  out  $clog2(DEPTH)+1  commands queued incl. in-flight
ctl_new_data  out  1  to controller new_data
ctl_addr  out  7  to controller addr
ctl_rw  out  1  to controller rw
ctl_data_in  out  8  to controller data_in
ctl_data_out  in  8  from controller data_out
ctl_bus_busy  in  1  from controller bus_busy
ctl_ack_error  in  1  from controller ack_error
ctl_done  in  1  from controller done

Behaviour:
- One clock, clk. Reset is synchronous, active-high, port rst. All state updates on posedge clk.
- Reset: all outputs 0, cmd_ready 0 while rst=1. FIFO flushed, FSM to IDLE, counters 0.
- Reset mid-transaction: ctl_new_data low the next cycle; the in-flight command is dropped with no response.
- FIFO:
  - Push on cmd_valid&cmd_ready.
  - Pop only on the response handshake (rsp_valid&rsp_ready); the head stays in the FIFO while in flight.
  - cmd_ready = !full; no pass-through when full.
  - Simultaneous push and pop when not full: count unchanged, both applied.
  - Pointers wrap modulo DEPTH.
- ctl_addr/ctl_rw/ctl_data_in always reflect the FIFO head registers. They are stable from WAIT_BUS through ACTIVE.
- FSM:
  - IDLE: FIFO non-empty -> WAIT_BUS. Clear tries and nack flag.
  - WAIT_BUS: ctl_bus_busy=0 -> LAUNCH.
  - LAUNCH: ctl_new_data=1. Timeout counter starts at 0. ctl_bus_busy=1 -> ctl_new_data=0 next cycle, -> ACTIVE.
  - ACTIVE: ctl_new_data=0.
    - ctl_ack_error=1 in any ACTIVE cycle, or in the ctl_done cycle, sets the nack flag.
    - On ctl_done: if nack and tries<MAX_RETRY -> tries+1, GAP.
    - Otherwise capture and -> RESPOND: status 00/01, rsp_rdata=ctl_data_out if read&ok else 0.
  - GAP: count GAP cycles, clear nack flag -> WAIT_BUS.
  - Timeout: counter reaching TIMEOUT in LAUNCH or ACTIVE -> status 10, rsp_rdata 0, ctl_new_data=0 -> RESPOND. No retry on timeout.
  - RESPOND: rsp_valid=1; rsp fields held stable until rsp_ready. On handshake pop FIFO -> IDLE.
- Latency: non-empty FIFO and idle bus -> ctl_new_data high 2 cycles after push.
- rsp_valid never drops without rsp_ready.
- ctl_done outside ACTIVE is ignored.
- pending = FIFO count. It decrements on the response handshake.

Test Plan:
- Write OK: push addr 0x6D, rw 0, wdata 0xA5; model accepts, done, no ack_error -> ctl_new_data high 2 cycles after push, drops 1 cycle after bus_busy; response addr 0x6D, status 00, rdata 0x00, tries 0; pending 1->0.
- Read OK: push addr 0x50, rw 1; controller returns data_out 0x3C at done -> rsp_rdata 0x3C, status 00.
- NACK retry: ack_error on first 2 attempts, clean third -> 3 launches, each retry at least GAP=16 cycles after the previous done; status 00, tries 2. With ack_error on all attempts -> status 01 after exactly 3 launches.
- Timeout: bus_busy rises but done never comes -> status 10 after TIMEOUT=4096 cycles from launch; ctl_new_data low; next command launches.
- FIFO full/backpressure: push 5 commands with rsp_ready=0 -> cmd_ready low after 4 accepted, pending=4, rsp held stable. Then raise rsp_ready -> responses in order, simultaneous push/pop keeps count.
- Reset mid-ACTIVE: assert rst during ACTIVE -> next cycle all outputs 0, pending 0, no response; fresh command after reset completes normally.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for i2c_controller: queues host transactions, launches them one at a time,
// retries NACKed transfers after an idle gap, aborts on timeout and returns one response per command.
module i2c_cmd_sequencer #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 4096,
    parameter int GAP       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [6:0]             cmd_addr,
    input  logic                   cmd_rw,
    input  logic [7:0]             cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [6:0]             rsp_addr,
    output logic [7:0]             rsp_rdata,
    output logic [1:0]             rsp_status,
    output logic [1:0]             rsp_tries,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   ctl_new_data,
    output logic [6:0]             ctl_addr,
    output logic                   ctl_rw,
    output logic [7:0]             ctl_data_in,
    input  logic [7:0]             ctl_data_out,
    input  logic                   ctl_bus_busy,
    input  logic                   ctl_ack_error,
    input  logic                   ctl_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [1:0]    ST_OK     = 2'b00;
    localparam logic [1:0]    ST_NACK   = 2'b01;
    localparam logic [1:0]    ST_TMO    = 2'b10;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_LAUNCH,
        S_ACTIVE,
        S_GAP,
        S_RESPOND
    } state_t;

    logic [6:0]    q_addr  [DEPTH];
    logic          q_rw    [DEPTH];
    logic [7:0]    q_wdata [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    state_t        state;
    logic [1:0]    tries;
    logic          nack;
    logic          nack_now;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !rst && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign pending   = count;

    // The head entry stays put while in flight, so the controller sees stable fields until the pop.
    assign ctl_addr    = q_addr[rd_ptr];
    assign ctl_rw      = q_rw[rd_ptr];
    assign ctl_data_in = q_wdata[rd_ptr];

    assign nack_now = nack || ctl_ack_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i]  <= '0;
                q_rw[i]    <= 1'b0;
                q_wdata[i] <= '0;
            end
        end else begin
            if (push) begin
                q_addr[wr_ptr]  <= cmd_addr;
                q_rw[wr_ptr]    <= cmd_rw;
                q_wdata[wr_ptr] <= cmd_wdata;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            tries        <= '0;
            nack         <= 1'b0;
            tcnt         <= '0;
            gcnt         <= '0;
            ctl_new_data <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_addr     <= '0;
            rsp_rdata    <= '0;
            rsp_status   <= '0;
            rsp_tries    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tries <= '0;
                    nack  <= 1'b0;
                    if (!empty) begin
                        state <= S_WAIT_BUS;
                    end
                end
                S_WAIT_BUS: begin
                    if (!ctl_bus_busy) begin
                        state        <= S_LAUNCH;
                        ctl_new_data <= 1'b1;
                        tcnt         <= '0;
                    end
                end
                S_LAUNCH: begin
                    if (tcnt == TMO_LAST) begin
                        ctl_new_data <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_addr     <= ctl_addr;
                        rsp_rdata    <= '0;
                        rsp_status   <= ST_TMO;
                        rsp_tries    <= tries;
                        state        <= S_RESPOND;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (ctl_bus_busy) begin
                            ctl_new_data <= 1'b0;
                            state        <= S_ACTIVE;
                        end
                    end
                end
                S_ACTIVE: begin
                    // A done on the same cycle as the deadline still counts as a completed transfer.
                    if (ctl_done) begin
                        if (nack_now && (tries < RETRY_MAX)) begin
                            tries <= tries + 2'd1;
                            nack  <= 1'b0;
                            gcnt  <= '0;
                            state <= S_GAP;
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_addr   <= ctl_addr;
                            rsp_rdata  <= (ctl_rw && !nack_now) ? ctl_data_out : 8'h00;
                            rsp_status <= nack_now ? ST_NACK : ST_OK;
                            rsp_tries  <= tries;
                            state      <= S_RESPOND;
                        end
                    end else if (tcnt == TMO_LAST) begin
                        rsp_valid  <= 1'b1;
                        rsp_addr   <= ctl_addr;
                        rsp_rdata  <= '0;
                        rsp_status <= ST_TMO;
                        rsp_tries  <= tries;
                        state      <= S_RESPOND;
                    end else begin
                        nack <= nack_now;
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_GAP: begin
                    nack <= 1'b0;
                    if (gcnt == GAP_LAST) begin
                        state <= S_WAIT_BUS;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        rsp_valid && !rsp_ready |=> rsp_valid && $stable({rsp_addr, rsp_rdata, rsp_status, rsp_tries}));
    assert property (@(posedge clk) disable iff (rst) count <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: emulated controller, per-command attempt plans and a
// behavioural response model checked every cycle, plus directed literal expectations.
module tb_i2c_cmd_sequencer;
    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 2;
    localparam int TIMEOUT   = 4096;
    localparam int GAP       = 16;
    localparam int NCMD      = 256;
    localparam int OK = 0, NK = 1, HANG = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [6:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_status;
    logic [1:0] rsp_tries;
    logic [2:0] pending;
    logic       ctl_new_data;
    logic [6:0] ctl_addr;
    logic       ctl_rw;
    logic [7:0] ctl_data_in;
    logic [7:0] ctl_data_out = '0;
    logic       ctl_bus_busy = 1'b0;
    logic       ctl_ack_error = 1'b0;
    logic       ctl_done = 1'b0;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .rsp_tries(rsp_tries), .pending(pending),
        .ctl_new_data(ctl_new_data), .ctl_addr(ctl_addr), .ctl_rw(ctl_rw), .ctl_data_in(ctl_data_in),
        .ctl_data_out(ctl_data_out), .ctl_bus_busy(ctl_bus_busy), .ctl_ack_error(ctl_ack_error),
        .ctl_done(ctl_done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-command record: what the host sent, how each attempt behaves, what came back.
    logic [6:0] c_addr [NCMD];
    logic       c_rw   [NCMD];
    logic [7:0] c_wd   [NCMD];
    int         plan   [NCMD][3];
    logic [7:0] p_data [NCMD];
    int         att_cnt[NCMD];
    logic [7:0] r_rd   [NCMD];
    logic [1:0] r_st   [NCMD];
    logic [1:0] r_tr   [NCMD];

    int push_idx = 0, pop_idx = 0, model_cnt = 0, cyc = 0;
    int nd_rise_cyc = 0, last_done_cyc = 0, last_done_cmd = -1;
    logic rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Earliest terminal attempt decides the response; all-NACK ends after MAX_RETRY+1 attempts.
    function automatic void model_rsp(input int c, output logic [1:0] st, output logic [1:0] tr,
                                      output logic [7:0] rd);
        st = 2'd1;
        tr = 2'(MAX_RETRY);
        rd = 8'h00;
        for (int a = MAX_RETRY; a >= 0; a--) begin
            if (plan[c][a] == HANG) begin
                st = 2'd2; tr = 2'(a); rd = 8'h00;
            end else if (plan[c][a] == OK) begin
                st = 2'd0; tr = 2'(a); rd = c_rw[c] ? p_data[c] : 8'h00;
            end
        end
    endfunction

    // Compare process: every cycle, outputs against the model.
    logic       p_rv = 0, p_rr = 0, p_nd = 0, p_bb = 0, p_rst = 0;
    logic [6:0] p_ra;
    logic [7:0] p_rd;
    logic [1:0] p_rs, p_rt;
    logic [1:0] m_st, m_tr;
    logic [7:0] m_rd;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("cmd_ready", cmd_ready, (!rst && model_cnt < DEPTH));
            if (p_rst) begin
                check("reset_outputs", {rsp_valid, ctl_new_data, pending, rsp_addr, rsp_rdata, rsp_status,
                                        rsp_tries, ctl_addr, ctl_rw, ctl_data_in}, 64'd0);
            end else if (cyc > 1) begin
                check("pending", pending, model_cnt);
                if (model_cnt > 0)
                    check("ctl_head", {ctl_addr, ctl_rw, ctl_data_in},
                          {c_addr[pop_idx], c_rw[pop_idx], c_wd[pop_idx]});
                if (p_rv && !p_rr)
                    check("rsp_hold", {rsp_valid, rsp_addr, rsp_rdata, rsp_status, rsp_tries},
                          {1'b1, p_ra, p_rd, p_rs, p_rt});
                if (p_nd && p_bb)
                    check("new_data_drop", ctl_new_data, 1'b0);
                if (ctl_new_data && !p_nd) begin
                    if (last_done_cmd == pop_idx)
                        check("retry_gap", (cyc - last_done_cyc >= GAP + 1), 1'b1);
                    nd_rise_cyc = cyc;
                end
                if (rsp_valid && !p_rv) begin
                    model_rsp(pop_idx, m_st, m_tr, m_rd);
                    check("launches", att_cnt[pop_idx], m_tr + 1);
                    if (m_st == 2'd2)
                        check("timeout_cycles", cyc - nd_rise_cyc, TIMEOUT);
                end
                if (ctl_done && model_cnt > 0) begin
                    last_done_cyc = cyc;
                    last_done_cmd = pop_idx;
                end
                if (rsp_valid && rsp_ready && !rst) begin
                    model_rsp(pop_idx, m_st, m_tr, m_rd);
                    check("rsp", {rsp_addr, rsp_rdata, rsp_status, rsp_tries},
                          {c_addr[pop_idx], m_rd, m_st, m_tr});
                    r_rd[pop_idx] = rsp_rdata;
                    r_st[pop_idx] = rsp_status;
                    r_tr[pop_idx] = rsp_tries;
                    pop_idx++;
                    model_cnt--;
                end
            end
            if (cmd_valid && cmd_ready && !rst) begin
                push_idx++;
                model_cnt++;
            end
            if (rst) begin
                model_cnt = 0;
                pop_idx = push_idx;
                last_done_cmd = -1;
            end
            p_rv = rsp_valid; p_rr = rsp_ready; p_nd = ctl_new_data; p_bb = ctl_bus_busy; p_rst = rst;
            p_ra = rsp_addr; p_rd = rsp_rdata; p_rs = rsp_status; p_rt = rsp_tries;
        end
    end

    // Emulated controller: each launch follows the planned outcome of the current attempt.
    int   dc, da, doc, dn;
    bit   dmode;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ctl_new_data && !rst) begin
                dc = pop_idx;
                da = att_cnt[dc];
                att_cnt[dc]++;
                doc = (da < 3) ? plan[dc][da] : OK;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                ctl_bus_busy = 1'b1;
                if (doc == HANG) begin
                    dn = 0;
                    while (!rsp_valid && !rst && dn < 2 * TIMEOUT) begin @(posedge clk); #1; dn++; end
                    ctl_bus_busy = 1'b0;
                end else begin
                    dmode = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    if (doc == NK && !dmode) begin
                        ctl_ack_error = 1'b1;
                        @(posedge clk); #1;
                        ctl_ack_error = 1'b0;
                    end
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ctl_done = 1'b1;
                    ctl_ack_error = (doc == NK) && dmode;
                    ctl_data_out = (doc == OK) ? p_data[dc] : 8'($urandom);
                    @(posedge clk); #1;
                    ctl_done = 1'b0;
                    ctl_ack_error = 1'b0;
                    ctl_bus_busy = 1'b0;
                    ctl_data_out = 8'($urandom);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic present(input logic [6:0] a, input logic rw, input logic [7:0] d,
                           input int o0, input int o1, input int o2, input logic [7:0] pd);
        c_addr[push_idx] = a; c_rw[push_idx] = rw; c_wd[push_idx] = d;
        plan[push_idx][0] = o0; plan[push_idx][1] = o1; plan[push_idx][2] = o2;
        p_data[push_idx] = pd; att_cnt[push_idx] = 0;
        cmd_addr = a; cmd_rw = rw; cmd_wdata = d; cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int  n = 0;
        bit  got = 0;
        while (!got && n < 20000) begin
            @(negedge clk);
            if (cmd_ready) got = 1; else n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("push_accepted", got, 1'b1);
    endtask

    task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] d,
                        input int o0, input int o1, input int o2, input logic [7:0] pd);
        present(a, rw, d, o0, o1, o2, pd);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        while ((pop_idx != push_idx || rsp_valid) && n < 3 * TIMEOUT) begin tick(1); n++; end
        check("drain", (pop_idx == push_idx), 1'b1);
        tick(2);
    endtask

    int idx, r;
    initial begin
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        check("reset_pending", pending, 3'd0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_new_data", ctl_new_data, 1'b0);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        // Write OK with launch latency
        idx = push_idx;
        push(7'h6D, 1'b0, 8'hA5, OK, OK, OK, 8'h00);
        @(negedge clk); check("lat_cycle1", ctl_new_data, 1'b0); check("pending_one", pending, 3'd1);
        @(negedge clk); check("lat_cycle2", ctl_new_data, 1'b0);
        @(negedge clk); check("lat_cycle3", ctl_new_data, 1'b1);
        drain();
        check("wr_ok", {r_st[idx], r_rd[idx], r_tr[idx]}, {2'b00, 8'h00, 2'd0});
        check("pending_zero", pending, 3'd0);

        // Read OK
        idx = push_idx;
        push(7'h50, 1'b1, 8'h00, OK, OK, OK, 8'h3C);
        drain();
        check("rd_ok", {r_st[idx], r_rd[idx]}, {2'b00, 8'h3C});

        // NACK twice then clean
        idx = push_idx;
        push(7'h22, 1'b0, 8'h5A, NK, NK, OK, 8'h00);
        drain();
        check("retry_ok", {r_st[idx], r_tr[idx], 8'(att_cnt[idx])}, {2'b00, 2'd2, 8'd3});

        // NACK on every attempt
        idx = push_idx;
        push(7'h31, 1'b1, 8'h00, NK, NK, NK, 8'h77);
        drain();
        check("nack_all", {r_st[idx], r_tr[idx], r_rd[idx], 8'(att_cnt[idx])}, {2'b01, 2'd2, 8'h00, 8'd3});

        // Timeout, then the queued command still runs
        idx = push_idx;
        push(7'h44, 1'b1, 8'h00, HANG, OK, OK, 8'hEE);
        push(7'h45, 1'b1, 8'h00, OK, OK, OK, 8'h9D);
        drain();
        check("timeout", {r_st[idx], r_rd[idx], r_tr[idx], 8'(att_cnt[idx])}, {2'b10, 8'h00, 2'd0, 8'd1});
        check("after_timeout", {r_st[idx+1], r_rd[idx+1]}, {2'b00, 8'h9D});

        // FIFO full with the response channel stalled
        rsp_ready = 1'b0;
        idx = push_idx;
        for (int i = 0; i < 4; i++) push(7'(7'h10 + i), 1'(i), 8'(i * 17), OK, OK, OK, 8'(8'hB0 + i));
        present(7'h14, 1'b0, 8'h99, OK, OK, OK, 8'h00);
        tick(40);
        @(negedge clk);
        check("full_cmd_ready", cmd_ready, 1'b0);
        check("full_pending", pending, 3'd4);
        check("full_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_accept();
        drain();
        for (int i = 0; i < 5; i++) check("full_order_status", r_st[idx+i], 2'b00);

        // Randomized traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       present(7'($urandom), 1'($urandom), 8'($urandom), OK, OK, OK, 8'($urandom));
            else if (r < 8)  present(7'($urandom), 1'($urandom), 8'($urandom), NK, OK, OK, 8'($urandom));
            else if (r == 8) present(7'($urandom), 1'($urandom), 8'($urandom), NK, NK, OK, 8'($urandom));
            else             present(7'($urandom), 1'($urandom), 8'($urandom), NK, NK, NK, 8'($urandom));
            wait_accept();
            tick($urandom_range(0, 3));
        end
        drain();
        rand_rdy = 1'b0;
        tick(1);
        rsp_ready = 1'b1;

        // Reset while a transfer is in flight with another queued
        push(7'h12, 1'b0, 8'h33, HANG, OK, OK, 8'h00);
        push(7'h13, 1'b1, 8'h00, OK, OK, OK, 8'h55);
        r = 0;
        while (!ctl_bus_busy && r < 100) begin tick(1); r++; end
        check("busy_before_reset", ctl_bus_busy, 1'b1);
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_pending", pending, 3'd0);
        check("midreset_outputs", {rsp_valid, ctl_new_data}, 2'b00);
        tick(3);
        idx = push_idx;
        push(7'h2A, 1'b1, 8'h00, OK, OK, OK, 8'hC3);
        drain();
        check("post_reset", {r_st[idx], r_rd[idx], r_tr[idx]}, {2'b00, 8'hC3, 2'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
